// File: rtl/multicycle_control_fsm_if.sv
// Memory port handshake between the multi-cycle control sequencer and the
// shared instruction/data memory.
//   mem_req   : access request, held until mem_ready
//   mem_we    : write strobe, valid with mem_req
//   adr_src   : 0 = address from PC, 1 = address from ALU result register
//   mem_ready : memory completes the current request this cycle
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle RV32I core. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath enables and
// mux selects, with a memory ready handshake, a wait-state timeout and a
// retired-instruction counter.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   mem             : memory handshake (master side: mem_req/mem_we/adr_src out,
//                     mem_ready in)
//   opcode, funct3, funct7b5, zero : instruction fields and ALU zero flag
//   ir_we, pc_we, reg_we           : datapath load enables
//   alu_src_a, alu_src_b, alu_op, result_src : datapath mux selects
//   instr_retired   : one-cycle pulse in the final cycle of each instruction
//   retire_count    : retired instruction count, wraps
//   halted, fault   : sticky stop / memory-timeout flags, cleared by rst
//
// Build option: define ILLEGAL_TRAP_EN to halt on an unknown opcode in an
// ILLEGAL state; otherwise an unknown opcode retires as a NOP.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_fsm_if.master mem,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct7b5,
  input  logic                    zero,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic                    reg_we,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              result_src,
  output logic                    instr_retired,
  output logic [RETIRE_W-1:0]     retire_count,
  output logic                    halted,
  output logic                    fault
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam bit              TMO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, FAULT, ILLEGAL
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [TMO_W-1:0] stall_cnt;
  logic             mem_phase;
  logic             stalled;
  logic             timeout_hit;
  logic             req;
  logic             we;
  logic             adr;

  // funct7b5 and funct3[2:1] are decoded by the ALU decoder, not here
  logic unused_fields;
  assign unused_fields = ^{funct7b5, funct3[2:1]};

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign mem.adr_src = adr;

  // A stall is a memory-phase cycle without mem_ready; hitting the limit
  // while still stalled diverts to FAULT (a late mem_ready still wins)
  assign mem_phase   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign stalled     = mem_phase && !mem.mem_ready;
  assign timeout_hit = TMO_EN && stalled && (stall_cnt == TMO_LIMIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_next    = state;
    req           = 1'b0;
    we            = 1'b0;
    adr           = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    reg_we        = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    result_src    = RES_ALUOUT;
    instr_retired = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        req        = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem.mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // branch/jump target precompute into the ALU result register
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXEC_R;
          OP_ITYPE:          state_next = EXEC_I;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = ILLEGAL;
`else
            instr_retired = 1'b1;
            state_next    = FETCH;
`endif
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        state_next = (opcode == OP_STORE) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        req = 1'b1;
        adr = 1'b1;
        if (mem.mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src    = RES_MEMDATA;
        reg_we        = 1'b1;
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      MEMWR: begin
        req = 1'b1;
        we  = 1'b1;
        adr = 1'b1;
        if (mem.mem_ready) begin
          instr_retired = 1'b1;
          state_next    = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_FUNCT;
        state_next = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_FUNCT;
        state_next = ALU_WB;
      end
      ALU_WB: begin
        reg_we        = 1'b1;
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        // funct3[0] selects bne over beq
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_SUB;
        pc_we         = zero ^ funct3[0];
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      JAL: begin
        // PC takes the precomputed target while the ALU forms oldPC+4 for rd
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_we      = 1'b1;
        state_next = ALU_WB;
      end
      FAULT, ILLEGAL: state_next = state;
      default:        state_next = IDLE;
    endcase
    if (timeout_hit) state_next = FAULT;
  end

  // Consecutive stall counter, cleared on mem_ready or any state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!stalled || (state_next != state)) begin
      stall_cnt <= '0;
    end else if (stall_cnt != '1) begin
      stall_cnt <= stall_cnt + TMO_W'(1);
    end
  end

  // Retire counter and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= '0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      if (instr_retired) retire_count <= retire_count + RETIRE_W'(1);
      if (state_next == FAULT) begin
        halted <= 1'b1;
        fault  <= 1'b1;
      end
      if (state_next == ILLEGAL) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  localparam int unsigned TMO = 4;
  localparam int unsigned RW  = 4;

  // Instruction phases as the specification names them
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_NOP = 3, PH_MEMADR = 4,
                 PH_MEMRD = 5, PH_MEMWB = 6, PH_MEMWR = 7, PH_EXEC_R = 8, PH_EXEC_I = 9,
                 PH_ALU_WB = 10, PH_BRANCH = 11, PH_JAL = 12, PH_FAULT = 13, PH_ILLEGAL = 14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic          zero;
  logic          ir_we, pc_we, reg_we, instr_retired, halted, fault;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic [RW-1:0] retire_count;

  multicycle_control_fsm_if mem_bus();

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .TMO_W(3), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .mem(mem_bus),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .instr_retired(instr_retired), .retire_count(retire_count), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [16:0]   act_ctl;
  logic [16:0]   exp_ctl;
  logic [RW-1:0] exp_cnt;
  logic [RW-1:0] model_cnt;
  bit            chk_en = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;
  int            pulses = 0;

  assign act_ctl = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.adr_src, ir_we, pc_we, reg_we,
                    alu_src_a, alu_src_b, alu_op, result_src, instr_retired, halted, fault};

  // Control word the specification prescribes for one cycle of a phase
  function automatic logic [16:0] exp_word(input int ph, input logic rdy, input logic z,
                                           input logic [2:0] f3);
    logic mreq, mwe, adr, irwe, pcwe, regwe, ret, hlt, flt;
    logic [1:0] sa, sb, op, rs;
    mreq = 0; mwe = 0; adr = 0; irwe = 0; pcwe = 0; regwe = 0; ret = 0; hlt = 0; flt = 0;
    sa = 2'b00; sb = 2'b00; op = 2'b00; rs = 2'b00;
    case (ph)
      PH_FETCH:   begin mreq = 1; sb = 2'b10; rs = 2'b10; irwe = rdy; pcwe = rdy; end
      PH_DECODE:  begin sa = 2'b01; sb = 2'b01; end
      PH_NOP:     begin sa = 2'b01; sb = 2'b01; ret = 1; end
      PH_MEMADR:  begin sa = 2'b10; sb = 2'b01; end
      PH_MEMRD:   begin mreq = 1; adr = 1; end
      PH_MEMWB:   begin rs = 2'b01; regwe = 1; ret = 1; end
      PH_MEMWR:   begin mreq = 1; mwe = 1; adr = 1; ret = rdy; end
      PH_EXEC_R:  begin sa = 2'b10; op = 2'b10; end
      PH_EXEC_I:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
      PH_ALU_WB:  begin regwe = 1; ret = 1; end
      PH_BRANCH:  begin sa = 2'b10; op = 2'b01; pcwe = z ^ f3[0]; ret = 1; end
      PH_JAL:     begin sa = 2'b01; sb = 2'b10; pcwe = 1; end
      PH_FAULT:   begin hlt = 1; flt = 1; end
      PH_ILLEGAL: begin hlt = 1; end
      default: ;
    endcase
    return {mreq, mwe, adr, irwe, pcwe, regwe, sa, sb, op, rs, ret, hlt, flt};
  endfunction

  // Single compare process: every active cycle, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (act_ctl !== exp_ctl || retire_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL cycle@%0t ctl got %05h want %05h, retire_count got %0d want %0d",
                 $time, act_ctl, exp_ctl, retire_count, exp_cnt);
      end
      if (instr_retired === 1'b1) pulses++;
    end
  end

  task automatic check_lit(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  // One clock cycle of a phase; called just after a rising edge
  task automatic step(input int ph, input logic rdy);
    logic [16:0] e;
    mem_bus.mem_ready = rdy;
    e       = exp_word(ph, rdy, zero, funct3);
    exp_ctl = e;
    exp_cnt = model_cnt;
    chk_en  = 1'b1;
    @(posedge clk);
    #1;
    if (e[2]) model_cnt = model_cnt + RW'(1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    model_cnt = '0;
    step(PH_IDLE, 1'b0);
    step(PH_IDLE, 1'b0);
    rst = 1'b0;
    step(PH_IDLE, 1'b1);
  endtask

  // Stalled memory phase: stall i has i earlier stalls; the one that finds
  // MEM_TIMEOUT earlier stalls still pending sends the FSM to FAULT
  task automatic mem_wait(input int ph, input int waits, inout int cycles, inout bit faulted);
    for (int i = 0; i < waits && !faulted; i++) begin
      step(ph, 1'b0);
      cycles++;
      if (TMO != 0 && i == int'(TMO)) faulted = 1'b1;
    end
  endtask

  // Whole instruction from FETCH to its final cycle
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int fw, input int mw, output int cycles, output bit faulted);
    opcode = opc; funct3 = f3; zero = z; funct7b5 = f3[1];
    cycles = 0; faulted = 1'b0;
    mem_wait(PH_FETCH, fw, cycles, faulted);
    if (faulted) return;
    step(PH_FETCH, 1'b1); cycles++;
    case (opc)
      OP_LOAD: begin
        step(PH_DECODE, 1'b1); step(PH_MEMADR, 1'b1); cycles += 2;
        mem_wait(PH_MEMRD, mw, cycles, faulted);
        if (faulted) return;
        step(PH_MEMRD, 1'b1); step(PH_MEMWB, 1'b1); cycles += 2;
      end
      OP_STORE: begin
        step(PH_DECODE, 1'b1); step(PH_MEMADR, 1'b1); cycles += 2;
        mem_wait(PH_MEMWR, mw, cycles, faulted);
        if (faulted) return;
        step(PH_MEMWR, 1'b1); cycles++;
      end
      OP_R:   begin step(PH_DECODE, 1'b1); step(PH_EXEC_R, 1'b1); step(PH_ALU_WB, 1'b1); cycles += 3; end
      OP_I:   begin step(PH_DECODE, 1'b1); step(PH_EXEC_I, 1'b1); step(PH_ALU_WB, 1'b1); cycles += 3; end
      OP_BR:  begin step(PH_DECODE, 1'b1); step(PH_BRANCH, 1'b1); cycles += 2; end
      OP_JAL: begin step(PH_DECODE, 1'b1); step(PH_JAL, 1'b1); step(PH_ALU_WB, 1'b1); cycles += 3; end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        step(PH_DECODE, 1'b1);
`else
        step(PH_NOP, 1'b1);
`endif
        cycles++;
      end
    endcase
  endtask

  initial begin
    int cyc;
    bit flt;
    rst = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    mem_bus.mem_ready = 1'b0;
    model_cnt = '0;
    @(posedge clk);
    #1;
    do_reset();

    // R-type, zero-wait memory
    run_instr(OP_R, 3'b000, 1'b0, 0, 0, cyc, flt);
    check_lit("lat_rtype", cyc, 4);
    check_lit("count_after_r", int'(retire_count), 1);

    // Load with three wait states in MEMRD
    run_instr(OP_LOAD, 3'b010, 1'b1, 0, 3, cyc, flt);
    check_lit("lat_load_3ws", cyc, 8);
    check_lit("count_after_ld", int'(retire_count), 2);

    // beq/bne with zero=1, then bne with zero=0
    run_instr(OP_BR, 3'b000, 1'b1, 0, 0, cyc, flt);
    check_lit("lat_beq", cyc, 3);
    run_instr(OP_BR, 3'b001, 1'b1, 0, 0, cyc, flt);
    check_lit("lat_bne", cyc, 3);
    run_instr(OP_BR, 3'b001, 1'b0, 0, 0, cyc, flt);
    check_lit("count_after_br", int'(retire_count), 5);

    // I-type, stores, jal, and stall boundaries that must not fault
    run_instr(OP_I, 3'b100, 1'b0, 0, 0, cyc, flt);
    run_instr(OP_STORE, 3'b010, 1'b0, 0, 2, cyc, flt);
    check_lit("lat_store_2ws", cyc, 6);
    run_instr(OP_JAL, 3'b000, 1'b1, 0, 0, cyc, flt);
    check_lit("lat_jal", cyc, 4);
    run_instr(OP_STORE, 3'b010, 1'b0, 4, 0, cyc, flt);
    check_lit("ready_at_limit_no_fault", int'(fault), 0);
    run_instr(OP_LOAD, 3'b010, 1'b0, 3, 3, cyc, flt);
    check_lit("lat_load_3f3m", cyc, 11);
    check_lit("count_after_mix", int'(retire_count), 10);

    // Unknown opcode
    run_instr(OP_BAD, 3'b000, 1'b0, 0, 0, cyc, flt);
`ifdef ILLEGAL_TRAP_EN
    step(PH_ILLEGAL, 1'b1);
    step(PH_ILLEGAL, 1'b0);
    step(PH_ILLEGAL, 1'b1);
    check_lit("illegal_halted", int'(halted), 1);
    check_lit("illegal_count", int'(retire_count), 10);
    do_reset();
`else
    check_lit("nop_count", int'(retire_count), 11);
`endif

    // Reset in the middle of a load aborts to IDLE
    opcode = OP_LOAD; funct3 = 3'b010; zero = 1'b0;
    step(PH_FETCH, 1'b1);
    step(PH_DECODE, 1'b1);
    step(PH_MEMADR, 1'b1);
    step(PH_MEMRD, 1'b0);
    do_reset();
    check_lit("count_after_abort", int'(retire_count), 0);

    // Memory never answers in FETCH: FAULT after the stall limit
    run_instr(OP_R, 3'b000, 1'b0, 20, 0, cyc, flt);
    check_lit("fault_fetch_cycles", cyc, 5);
    check_lit("fault_detected", int'(flt), 1);
    step(PH_FAULT, 1'b0);
    step(PH_FAULT, 1'b1);
    step(PH_FAULT, 1'b0);
    check_lit("fault_sticky", int'(fault), 1);
    check_lit("halted_sticky", int'(halted), 1);
    do_reset();
    check_lit("fault_cleared", int'(fault), 0);

    // Seventeen R-types wrap the 4-bit counter to 1
    pulses = 0;
    for (int k = 0; k < 17; k++) run_instr(OP_R, 3'(k), k[0], 0, 0, cyc, flt);
    check_lit("retire_pulses", pulses, 17);
    check_lit("retire_wrap", int'(retire_count), 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
